player_input_ctrl: RTL and testbench
====================================

Name: player_input_ctrl

Overview:
- Front-end stage that feeds player_move.
- Synchronises and debounces the raw player buttons, then turns them into frame-aligned move_left / move_right / jump / move_enable requests.
- Runs a small action FSM (idle / attack / hitstun) that gates movement while the fighter is busy.
- All request outputs change only on SCEN frame ticks, so player_move samples each one for exactly one frame.

Parameters:
- DEBOUNCE_FRAMES, 3: consecutive SCEN ticks a synchronised button must hold a new level before the debounced level changes.
- ATTACK_FRAMES, 12: frames spent in ATTACK.
- HITSTUN_FRAMES, 20: frames spent in HITSTUN.
- JUMP_BUF_FRAMES, 6: lifetime in frames of a buffered jump press (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- SCEN  in  1  one-clk frame-tick enable
- btn_left  in  1  raw asynchronous button
- btn_right  in  1  raw asynchronous button
- btn_jump  in  1  raw asynchronous button
- btn_attack  in  1  raw asynchronous button
- hit  in  1  one-clk pulse from combat logic: this player was struck
- jump_active  in  1  feedback from player_move
- move_left  out  1  walk/drift-left request
- move_right  out  1  walk/drift-right request
- jump  out  1  one-frame jump request
- move_enable  out  1  position-update enable for player_move
- attack_start  out  1  one-frame pulse when ATTACK is entered
- action_state  out  2  00 IDLE, 01 ATTACK, 10 HITSTUN

Behaviour:
- Reset (reset=0, asynchronous) drives:
  - all outputs to 0, except move_enable=1;
  - FSM to IDLE;
  - synchronisers, debounced levels, counters and jump buffer to 0.
- Synchronisation:
  - each button passes through a 2-flop synchroniser on every clk, independent of SCEN.
- Debounce, evaluated on SCEN only:
  - per-button counter increments while sync level != debounced level, and clears otherwise;
  - debounced level flips when the counter reaches DEBOUNCE_FRAMES-1; the counter then clears;
  - a change therefore takes effect DEBOUNCE_FRAMES ticks after it is first sampled.
- Edges:
  - jump_press and attack_press are rising edges of the debounced levels, each one frame wide;
  - they are computed against the previous frame's debounced value.
- All registered outputs update only when SCEN=1 and hold otherwise.
- Direction:
  - move_left = deb_left & ~deb_right;
  - move_right = deb_right & ~deb_left;
  - both 0 when both or neither button is held, and both 0 in ATTACK/HITSTUN unless jump_active=1.
- FSM, advancing on SCEN:
  - IDLE → ATTACK on attack_press. Loads the counter with ATTACK_FRAMES-1 and asserts attack_start for that frame.
  - ATTACK → IDLE when the counter reaches 0; otherwise it decrements.
  - Any state → HITSTUN on hit. Loads HITSTUN_FRAMES-1 and aborts any attack with no attack_start.
  - HITSTUN → IDLE when the counter reaches 0.
  - hit pulses are latched (sticky) between SCEN ticks and consumed on the next tick.
  - A hit during HITSTUN reloads the counter.
- move_enable = 1 in IDLE, or whenever jump_active=1, so an airborne arc always completes. Otherwise move_enable = 0.
- Jump:
  - jump=1 for exactly one frame when jump_press occurs, FSM is IDLE, and jump_active=0.
  - Simultaneous attack_press and jump_press in IDLE: attack wins and the jump is dropped.
  - jump_press while airborne or in ATTACK/HITSTUN: dropped, unless the optional feature is compiled in.
- Reset asserted mid-attack or mid-hitstun: returns to IDLE immediately with no pending pulses.

Optional Feature:
- Macro: PLAYER_INPUT_JUMP_BUF_EN.
- Defined:
  - a jump_press that cannot issue sets a buffer with lifetime JUMP_BUF_FRAMES;
  - the buffer decrements each SCEN tick;
  - jump is issued on the first frame with IDLE & ~jump_active while the buffer is nonzero, and the buffer then clears;
  - the buffer is cleared by hit or by expiry.
- Undefined: no buffer logic; unissuable presses are dropped.

Test Plan:
- Hold btn_right from frame 0 with DEBOUNCE_FRAMES=3 → move_right=1 by frame 5 at the latest; a 2-frame glitch on btn_left never sets move_left.
- Press btn_left and btn_right together, both debounced → move_left=0 and move_right=0 on every frame.
- btn_jump rising with jump_active=0 and the button held for 10 frames → jump=1 for exactly one SCEN frame, then 0.
- btn_attack press → attack_start for one frame, action_state=01 for 12 frames, move_enable=0 throughout, then IDLE with move_enable=1.
- hit pulse at frame 5 of an attack → action_state=10 for 20 frames; a second hit at hitstun frame 10 extends it to 30 frames in total; jump_active=1 keeps move_enable=1.
- With PLAYER_INPUT_JUMP_BUF_EN, jump pressed 3 frames before jump_active falls → jump issued on the first frame jump_active=0; pressed 7 frames before → no jump. Without the macro → no jump in either case.

Source files
------------

// File: rtl/player_input_ctrl.sv
// Button sync/debounce plus idle/attack/hitstun FSM producing frame-aligned move requests.
// Outputs are registered and change only on SCEN; the optional jump buffer is enabled by PLAYER_INPUT_JUMP_BUF_EN.
module player_input_ctrl #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int ATTACK_FRAMES   = 12,
    parameter int HITSTUN_FRAMES  = 20
`ifdef PLAYER_INPUT_JUMP_BUF_EN
    ,
    parameter int JUMP_BUF_FRAMES = 6
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       hit,
    input  logic       jump_active,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       move_enable,
    output logic       attack_start,
    output logic [1:0] action_state
);
    localparam int DB_W    = (DEBOUNCE_FRAMES > 2) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam int CNT_MAX = (ATTACK_FRAMES > HITSTUN_FRAMES) ? ATTACK_FRAMES : HITSTUN_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
    localparam logic [CNT_W-1:0] ATK_LOAD = CNT_W'(ATTACK_FRAMES - 1);
    localparam logic [CNT_W-1:0] HIT_LOAD = CNT_W'(HITSTUN_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ATTACK  = 2'b01,
        ST_HITSTUN = 2'b10
    } state_t;

    // Bit order: 0 left, 1 right, 2 jump, 3 attack.
    logic [3:0]            btn_raw;
    logic [3:0]            sync1_q, sync2_q;
    logic [3:0]            deb_q, deb_d;
    logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic                  hit_pend_q, hit_pend_d;
    logic                  hit_evt, jump_press, attack_press;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  move_left_q, move_left_d, move_right_q, move_right_d;
    logic                  jump_q, jump_d, move_enable_q, move_enable_d;
    logic                  attack_start_q, attack_start_d;
    logic                  move_ok, can_jump, jump_fire, jbuf_live;

    assign btn_raw = {btn_attack, btn_jump, btn_right, btn_left};

    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        if (SCEN) begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        deb_d[i]    = ~deb_q[i];
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
                    end
                end else begin
                    db_cnt_d[i] = '0;
                end
            end
        end
    end

    // Edges compare this frame's debounced level with last frame's; zero when SCEN is low.
    assign jump_press   = deb_d[2] & ~deb_q[2];
    assign attack_press = deb_d[3] & ~deb_q[3];
    assign hit_evt      = hit_pend_q | hit;
    assign hit_pend_d   = SCEN ? 1'b0 : (hit_pend_q | hit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            db_cnt_q   <= '0;
            hit_pend_q <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            db_cnt_q   <= db_cnt_d;
            hit_pend_q <= hit_pend_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (SCEN) begin
            if (hit_evt) begin
                state_d = ST_HITSTUN;
                cnt_d   = HIT_LOAD;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (attack_press) begin
                            state_d = ST_ATTACK;
                            cnt_d   = ATK_LOAD;
                        end
                    end
                    ST_ATTACK, ST_HITSTUN: begin
                        if (cnt_q == '0) state_d = ST_IDLE;
                        else             cnt_d   = cnt_q - CNT_ONE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    assign move_ok   = (state_d == ST_IDLE) | jump_active;
    assign can_jump  = (state_q == ST_IDLE) & ~jump_active & ~attack_press & ~hit_evt;
    assign jump_fire = can_jump & (jump_press | jbuf_live);

`ifdef PLAYER_INPUT_JUMP_BUF_EN
    localparam int BUF_W = $clog2(JUMP_BUF_FRAMES + 1);
    localparam logic [BUF_W-1:0] BUF_LOAD = BUF_W'(JUMP_BUF_FRAMES);
    localparam logic [BUF_W-1:0] BUF_ONE  = BUF_W'(1);
    logic [BUF_W-1:0] jbuf_q, jbuf_d;

    assign jbuf_live = (jbuf_q != '0);

    always_comb begin
        jbuf_d = jbuf_q;
        if (SCEN) begin
            if (hit_evt || jump_fire) jbuf_d = '0;
            else if (jump_press)      jbuf_d = BUF_LOAD;
            else if (jbuf_live)       jbuf_d = jbuf_q - BUF_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) jbuf_q <= '0;
        else        jbuf_q <= jbuf_d;
    end
`else
    assign jbuf_live = 1'b0;
`endif

    always_comb begin
        move_left_d    = move_left_q;
        move_right_d   = move_right_q;
        jump_d         = jump_q;
        move_enable_d  = move_enable_q;
        attack_start_d = attack_start_q;
        if (SCEN) begin
            move_left_d    = deb_d[0] & ~deb_d[1] & move_ok;
            move_right_d   = deb_d[1] & ~deb_d[0] & move_ok;
            jump_d         = jump_fire;
            move_enable_d  = move_ok;
            attack_start_d = (state_q == ST_IDLE) & attack_press & ~hit_evt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            move_left_q    <= 1'b0;
            move_right_q   <= 1'b0;
            jump_q         <= 1'b0;
            move_enable_q  <= 1'b1;
            attack_start_q <= 1'b0;
        end else begin
            move_left_q    <= move_left_d;
            move_right_q   <= move_right_d;
            jump_q         <= jump_d;
            move_enable_q  <= move_enable_d;
            attack_start_q <= attack_start_d;
        end
    end

    assign move_left    = move_left_q;
    assign move_right   = move_right_q;
    assign jump         = jump_q;
    assign move_enable  = move_enable_q;
    assign attack_start = attack_start_q;
    assign action_state = state_q;
endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_player_input_ctrl;
    localparam int DEB  = 3;
    localparam int ATK  = 12;
    localparam int HST  = 20;
    localparam int JBUF = 6;

    logic clk = 1'b0, reset = 1'b0, SCEN = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0, btn_attack = 1'b0;
    logic hit = 1'b0, jump_active = 1'b0;
    logic move_left, move_right, jump, move_enable, attack_start;
    logic [1:0] action_state;

    int vectors = 0;
    int miscompares = 0;
    logic check_en = 1'b0;

    logic cur_l = 1'b0, cur_r = 1'b0, cur_j = 1'b0, cur_a = 1'b0, cur_ja = 1'b0;

    // Model state: debounced levels, consecutive-disagree run lengths, mode and frames left.
    logic [3:0] m_deb;
    int m_run [4];
    int m_mode;
    int m_left;
    int m_buf;
    logic e_ml, e_mr, e_j, e_me, e_as;
    logic [1:0] e_st;

    always #5 clk = ~clk;

    player_input_ctrl dut (
        .clk(clk), .reset(reset), .SCEN(SCEN),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_attack(btn_attack),
        .hit(hit), .jump_active(jump_active),
        .move_left(move_left), .move_right(move_right), .jump(jump),
        .move_enable(move_enable), .attack_start(attack_start), .action_state(action_state)
    );

    task automatic model_reset();
        m_deb = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_mode = 0; m_left = 0; m_buf = 0;
        e_ml = 0; e_mr = 0; e_j = 0; e_me = 1; e_as = 0; e_st = 2'b00;
    endtask

    task automatic model_tick(input logic [3:0] raw, input logic ja, input logic hev);
        logic [3:0] old;
        logic jp, ap, was_idle, ok, fire, mov;
        old = m_deb;
        for (int i = 0; i < 4; i++) begin
            if (raw[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = ~m_deb[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        jp = m_deb[2] & ~old[2];
        ap = m_deb[3] & ~old[3];
        was_idle = (m_mode == 0);
        if (hev) begin
            m_mode = 2; m_left = HST;
        end else if (m_mode == 0) begin
            if (ap) begin m_mode = 1; m_left = ATK; end
        end else begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
        ok = was_idle & ~ja & ~ap & ~hev;
`ifdef PLAYER_INPUT_JUMP_BUF_EN
        fire = ok & (jp | (m_buf > 0));
        if (hev || fire) m_buf = 0;
        else if (jp)     m_buf = JBUF;
        else if (m_buf > 0) m_buf--;
`else
        fire = ok & jp;
`endif
        mov  = (m_mode == 0) | ja;
        e_ml = m_deb[0] & ~m_deb[1] & mov;
        e_mr = m_deb[1] & ~m_deb[0] & mov;
        e_j  = fire;
        e_me = mov;
        e_as = was_idle & ap & ~hev;
        e_st = m_mode[1:0];
    endtask

    always @(posedge clk) begin
        #1;
        if (check_en) begin
            vectors++;
            if ({move_left, move_right, jump, move_enable, attack_start, action_state} !==
                {e_ml, e_mr, e_j, e_me, e_as, e_st}) begin
                miscompares++;
                $display("FAIL cycle_cmp t=%0t ml/mr/j/me/as/st got %b%b%b%b%b%b expected %b%b%b%b%b%b",
                         $time, move_left, move_right, jump, move_enable, attack_start, action_state,
                         e_ml, e_mr, e_j, e_me, e_as, e_st);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame: inputs change at its start, optional hit on clock hk, SCEN on the last clock.
    task automatic frame(input int hk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                btn_left = cur_l; btn_right = cur_r; btn_jump = cur_j; btn_attack = cur_a;
                jump_active = cur_ja;
            end
            hit  = (c == hk);
            SCEN = (c == 3);
            if (c == 3) model_tick({cur_a, cur_j, cur_r, cur_l}, cur_ja, (hk >= 0) && (hk <= 3));
        end
        @(negedge clk);
        SCEN = 1'b0;
        hit  = 1'b0;
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) frame(-1);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        SCEN = 0; hit = 0;
        cur_l = 0; cur_r = 0; cur_j = 0; cur_a = 0; cur_ja = 0;
        btn_left = 0; btn_right = 0; btn_jump = 0; btn_attack = 0; jump_active = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic buf_case(input int k, output int jumps);
        jumps = 0;
        cur_ja = 1; cur_j = 1;
        for (int f = 0; f < 2 + k; f++) begin frame(-1); jumps += jump; end
        cur_ja = 0;
        for (int f = 0; f < 6; f++) begin frame(-1); jumps += jump; end
        cur_j = 0;
        idle_frames(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

    initial begin
        int first, seen, cnt, cnt2, cnt3, hs, ja_me, hk, jumps;
        model_reset();
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        release_reset();
        @(negedge clk);
        check("reset_state", {move_left, move_right, jump, move_enable, attack_start, action_state}, 7'b0001000);

        // Right held: debounced on the third tick.
        cur_r = 1; first = -1;
        for (int f = 0; f < 6; f++) begin
            frame(-1);
            if (move_right && first < 0) first = f;
        end
        check("right_debounce_frame", first, 2);

        // Two-frame glitch on left never reaches the output.
        cur_l = 1; seen = 0;
        for (int f = 0; f < 2; f++) begin frame(-1); seen |= move_left; end
        cur_l = 0;
        for (int f = 0; f < 4; f++) begin frame(-1); seen |= move_left; end
        check("left_glitch_ignored", seen, 0);
        check("right_held_through_glitch", move_right, 1);

        cur_r = 0; idle_frames(4);
        check("released_no_dir", {move_left, move_right}, 0);
        cur_l = 1; cur_r = 1; seen = 0;
        for (int f = 0; f < 8; f++) begin frame(-1); seen |= move_left | move_right; end
        check("both_held_no_dir", seen, 0);
        cur_l = 0; cur_r = 0; idle_frames(4);

        // Jump held for 10 frames gives a single one-frame request.
        cur_j = 1; cnt = 0;
        for (int f = 0; f < 10; f++) begin frame(-1); cnt += jump; end
        check("jump_one_frame", cnt, 1);
        cur_j = 0; idle_frames(4);

        // Attack: one start pulse, 12 frames in ATTACK with movement disabled.
        cur_a = 1; cnt = 0; cnt2 = 0; cnt3 = 0;
        for (int f = 0; f < 18; f++) begin
            frame(-1);
            cnt  += attack_start;
            cnt2 += (action_state == 2'b01);
            cnt3 += !move_enable;
        end
        check("attack_start_frames", cnt, 1);
        check("attack_len", cnt2, ATK);
        check("attack_me_low_frames", cnt3, ATK);
        check("attack_done_state", action_state, 0);
        check("attack_done_me", move_enable, 1);
        cur_a = 0; idle_frames(4);

        // Hit from idle: 20 frames of HITSTUN.
        frame(1);
        hs = (action_state == 2'b10);
        for (int f = 0; f < 40; f++) begin frame(-1); hs += (action_state == 2'b10); end
        check("hitstun_len", hs, HST);

        // Hit at attack frame 5, second hit at hitstun frame 10: 30 frames in total.
        cur_a = 1;
        idle_frames(3);
        check("attack_entered", action_state, 1);
        idle_frames(4);
        frame(1);
        check("hit_aborts_attack", action_state, 2);
        check("hit_no_attack_start", attack_start, 0);
        hs = 1; ja_me = 0;
        for (int i = 0; i < 9; i++) begin
            cur_ja = (i >= 4 && i <= 6);
            frame(-1);
            hs += (action_state == 2'b10);
            if (cur_ja) ja_me += move_enable;
        end
        cur_ja = 0;
        check("airborne_me_in_hitstun", ja_me, 3);
        frame(3);
        hs += (action_state == 2'b10);
        for (int f = 0; f < 40; f++) begin frame(-1); hs += (action_state == 2'b10); end
        check("hitstun_extended_len", hs, 30);
        cur_a = 0; idle_frames(4);

        // Asynchronous reset in the middle of an attack.
        cur_a = 1; idle_frames(6);
        check("attack_before_reset", action_state, 1);
        assert_reset();
        @(negedge clk);
        check("reset_mid_attack", {move_left, move_right, jump, move_enable, attack_start, action_state}, 7'b0001000);
        release_reset();
        idle_frames(2);

        // Jump pressed while airborne, landing 3 or 7 frames later.
        buf_case(3, jumps);
`ifdef PLAYER_INPUT_JUMP_BUF_EN
        check("jump_buf_3_frames", jumps, 1);
`else
        check("jump_buf_3_frames", jumps, 0);
`endif
        buf_case(7, jumps);
        check("jump_buf_7_frames", jumps, 0);

        // Random traffic checked cycle by cycle against the model.
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(4) == 0) cur_l = ~cur_l;
            if ($urandom_range(4) == 0) cur_r = ~cur_r;
            if ($urandom_range(3) == 0) cur_j = ~cur_j;
            if ($urandom_range(4) == 0) cur_a = ~cur_a;
            if ($urandom_range(7) == 0) cur_ja = ~cur_ja;
            hk = -1;
            if ($urandom_range(9) == 0) hk = int'($urandom_range(3));
            if (f == 200) begin
                assert_reset();
                repeat (2) @(negedge clk);
                release_reset();
            end
            frame(hk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
